// File: rtl/tl_execute_pkg.sv
// Shared encodings for the MDU execute stage: MDU op codes, forwarding selects,
// control-bus bit positions and ALU opcodes.
package tl_execute_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIVU  = 3'd2,
    MDU_MFHI  = 3'd3,
    MDU_MFLO  = 3'd4
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int ALUSRC    = 6;
  localparam int BRANCH_EQ = 2;
  localparam int BRANCH_NE = 7;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  function automatic logic is_mdu_start(input logic [2:0] op);
    return (op == MDU_MULTU) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/adder.sv
// Plain modulo-2^LEN adder.
module adder #(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  output logic [LEN-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/alu.sv
// Combinational ALU with zero flag used for branch resolution.
module alu
  import tl_execute_pkg::*;
#(
  parameter int LEN   = 32,
  parameter int NB_OP = 4
) (
  input  logic [LEN-1:0]   a,
  input  logic [LEN-1:0]   b,
  input  logic [NB_OP-1:0] op,
  output logic [LEN-1:0]   result,
  output logic             zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_XOR: result = a ^ b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(LEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mdu_iterative.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle,
// LEN cycles in BUSY. HI/LO are only written on the final step.
module mdu_iterative
  import tl_execute_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  input  logic           flush,
  output logic           busy,
  output logic           last,
  output logic [LEN-1:0] hi,
  output logic [LEN-1:0] lo
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN-1);

  mdu_state_e state, nxt;
  logic [CW-1:0]  cnt;
  logic           is_div;
  logic [LEN-1:0] dvd, opb, p_hi, p_lo, n_hi, n_lo;
  logic [LEN:0]   mul_sum, div_sh;
  logic           div_ge;

  assign busy = (state == MDU_BUSY);
  assign last = busy && (cnt == CNT_LAST);

  always_comb begin
    nxt = state;
    case (state)
      MDU_IDLE: if (start && !flush) nxt = MDU_BUSY;
      MDU_BUSY: if (flush || last)   nxt = MDU_IDLE;
      default:  nxt = MDU_IDLE;
    endcase
  end

  // p_hi holds the running partial product / remainder, p_lo the multiplier / quotient.
  always_comb begin
    mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opb} : '0);
    div_sh  = {p_hi, p_lo[LEN-1]};
    div_ge  = (div_sh >= {1'b0, opb});
    n_hi    = '0;
    n_lo    = '0;
    if (is_div) begin
      n_hi = div_ge ? (div_sh[LEN-1:0] - opb) : div_sh[LEN-1:0];
      n_lo = {p_lo[LEN-2:0], div_ge};
    end else begin
      {n_hi, n_lo} = {mul_sum, p_lo[LEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MDU_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      dvd    <= '0;
      opb    <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= nxt;
      if (state == MDU_IDLE) begin
        if (start && !flush) begin
          cnt    <= '0;
          is_div <= (op == MDU_DIVU);
          dvd    <= a;
          opb    <= b;
          p_hi   <= '0;
          p_lo   <= a;
        end
      end else if (!flush) begin
        cnt  <= cnt + 1'b1;
        p_hi <= n_hi;
        p_lo <= n_lo;
        if (last) begin
          if (is_div && opb == '0) begin
            hi <= dvd;
            lo <= '1;
          end else begin
            hi <= n_hi;
            lo <= n_lo;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mux.sv
// Two-input mux; sel=1 picks b.
module mux #(
  parameter int LEN = 32
) (
  input  logic           sel,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  output logic [LEN-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/tl_execute_mdu.sv
// Execute stage with forwarding, BEQ/BNE resolution, flush, iterative MDU and
// the EX/MEM pipeline register.
module tl_execute_mdu
  import tl_execute_pkg::*;
#(
  parameter int LEN               = 32,
  parameter int NB_SENIAL_CONTROL = 8,
  parameter int NB_ALU_CONTROL    = 4,
  parameter int NB_REG_ADDR       = 5
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  input  logic                         i_flush,
  input  logic [LEN-1:0]               i_adder_id,
  input  logic [LEN-1:0]               i_dato1,
  input  logic [LEN-1:0]               i_dato2,
  input  logic [LEN-1:0]               i_sign_extend,
  input  logic [NB_SENIAL_CONTROL-1:0] i_senial_control,
  input  logic [NB_ALU_CONTROL-1:0]    i_alu_control,
  input  logic [2:0]                   i_mdu_op,
  input  logic [1:0]                   i_fwd_a,
  input  logic [1:0]                   i_fwd_b,
  input  logic [LEN-1:0]               i_fwd_mem,
  input  logic [LEN-1:0]               i_fwd_wb,
  input  logic [NB_REG_ADDR-1:0]       i_rd_addr,
  output logic [LEN-1:0]               o_add_execute,
  output logic [LEN-1:0]               o_alu_result,
  output logic [LEN-1:0]               o_dato2,
  output logic [NB_SENIAL_CONTROL-1:0] o_senial_control,
  output logic [NB_REG_ADDR-1:0]       o_rd_addr,
  output logic                         o_valid,
  output logic                         o_PCSrc,
  output logic                         o_stall
);

  function automatic logic [LEN-1:0] fwd(input logic [1:0] sel, input logic [LEN-1:0] rf,
                                         input logic [LEN-1:0] mem, input logic [LEN-1:0] wb);
    case (sel)
      FWD_WB:  return wb;
      FWD_MEM: return mem;
      default: return rf;
    endcase
  endfunction

  logic [LEN-1:0] opa, opb, alu_b, alu_res, br_target, hi, lo, result;
  logic           zero, start_op, busy, last;

  assign opa = fwd(i_fwd_a, i_dato1, i_fwd_mem, i_fwd_wb);
  assign opb = fwd(i_fwd_b, i_dato2, i_fwd_mem, i_fwd_wb);

  mux #(.LEN(LEN)) u_alusrc (
    .sel (i_senial_control[ALUSRC]),
    .a   (opb),
    .b   (i_sign_extend),
    .y   (alu_b)
  );

  alu #(.LEN(LEN), .NB_OP(NB_ALU_CONTROL)) u_alu (
    .a      (opa),
    .b      (alu_b),
    .op     (i_alu_control),
    .result (alu_res),
    .zero   (zero)
  );

  adder #(.LEN(LEN)) u_br_adder (
    .a   (i_adder_id),
    .b   (i_sign_extend << 2),
    .sum (br_target)
  );

  assign start_op = is_mdu_start(i_mdu_op);

  mdu_iterative #(.LEN(LEN)) u_mdu (
    .clk   (i_clk),
    .rst_n (i_rst),
    .start (i_valid & start_op),
    .op    (i_mdu_op),
    .a     (opa),
    .b     (opb),
    .flush (i_flush),
    .busy  (busy),
    .last  (last),
    .hi    (hi),
    .lo    (lo)
  );

  // The MDU instruction is held in EX until its final BUSY cycle, where it retires.
  assign o_stall = i_valid & ~i_flush & ((~busy & start_op) | (busy & ~last));
  assign o_PCSrc = i_valid & ~i_flush & ~o_stall &
                   ((i_senial_control[BRANCH_EQ] & zero) | (i_senial_control[BRANCH_NE] & ~zero));

  always_comb begin
    result = alu_res;
    case (i_mdu_op)
      MDU_MFHI:            result = hi;
      MDU_MFLO:            result = lo;
      MDU_MULTU, MDU_DIVU: result = '0;
      default:             result = alu_res;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_add_execute    <= '0;
      o_alu_result     <= '0;
      o_dato2          <= '0;
      o_senial_control <= '0;
      o_rd_addr        <= '0;
      o_valid          <= 1'b0;
    end else begin
      o_valid <= i_valid & ~i_flush & ~o_stall;
      if (!o_stall) begin
        o_add_execute    <= br_target;
        o_alu_result     <= result;
        o_dato2          <= opb;
        o_senial_control <= i_senial_control;
        o_rd_addr        <= i_rd_addr;
      end
    end
  end

endmodule
